fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter N, default 64, width of PC and addresses.
REQ-002 Parameter DEPTH, default 4, instruction buffer entries (power of two, >=2).
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 PCSrc_F  input  1  redirect request (taken branch or jump).
REQ-007 PCBranch_F  input  N  redirect target address.
REQ-008 imem_req  output  1  instruction memory read request.
REQ-009 imem_addr  output  N  instruction memory read address.
REQ-010 imem_rvalid  input  1  read data valid; at most one per accepted request.
REQ-011 imem_rdata  input  32  read instruction word.
REQ-012 valid_D  output  1  head entry is valid for decode.
REQ-013 ready_D  input  1  decode accepts the head entry this cycle.
REQ-014 instr_D  output  32  head instruction, feeds decode instr_D.
REQ-015 pc_D  output  N  PC of the head instruction.

Function
REQ-016 PC register shall hold the next fetch address and advance by 4 when a response is written into the buffer.
REQ-017 At most one memory request shall be outstanding; states are IDLE and WAIT.
REQ-018 IDLE->WAIT: imem_req=1 when buffer occupancy plus outstanding count < DEPTH; request accepted that cycle.
REQ-019 In WAIT, imem_req=0 and imem_addr shall hold the requested address until imem_rvalid.
REQ-020 WAIT->IDLE on imem_rvalid; {imem_rdata, requested address} written to buffer tail unless the drop flag is set.
REQ-021 A new request may be issued in the same cycle as imem_rvalid (back-to-back) if space permits.
REQ-022 Buffer is a DEPTH-entry circular FIFO; pointers wrap modulo DEPTH; count range 0..DEPTH.
REQ-023 valid_D=1 iff count>0; instr_D/pc_D come from the head entry.
REQ-024 Pop when valid_D&&ready_D; simultaneous push and pop leave count unchanged.
REQ-025 Buffer shall never overflow; no request is issued when a response could exceed DEPTH.
REQ-026 PCSrc_F=1: PC <= PCBranch_F, buffer flushed (count=0, pointers=0), valid_D=0 next cycle.
REQ-027 Redirect in WAIT: set drop flag; the pending response is discarded and clears the flag; no new request until then.
REQ-028 Redirect in the same cycle as imem_rvalid: that response is discarded; next request uses PCBranch_F.
REQ-029 Redirect has priority over push and pop in the same cycle; a pop coinciding with redirect is still consumed by decode.
REQ-030 instr_D/pc_D shall be stable while valid_D=1 and ready_D=0.

Reset
REQ-031 While reset=0: PC=RESET_PC, state=IDLE, count=0, pointers=0, drop=0, imem_req=0, valid_D=0, instr_D=0, pc_D=0.
REQ-032 Reset assertion mid-WAIT abandons the request; a late imem_rvalid after release with no outstanding request shall be ignored.
REQ-033 First request shall be issued in the first cycle after reset release, at RESET_PC.

Verification
REQ-034 Reset release, 1-cycle memory, ready_D=1 -> decode receives PCs 0,4,8,12 in order with matching words.
REQ-035 ready_D=0 for 10 cycles -> exactly DEPTH=4 entries buffered, imem_req held 0, head stable; release -> 4 pops then fetch resumes at 16.
REQ-036 Redirect to 0x100 during WAIT for PC 8 -> response for 8 dropped; next request 0x100; valid_D=0 until 0x100 returns.
REQ-037 Redirect in the same cycle as imem_rvalid with buffer full and pop -> buffer empty, drop clear, next imem_addr = target.
REQ-038 Reset pulse while WAIT with a 3-cycle memory -> outputs zero immediately; after release first imem_addr=RESET_PC, stale rvalid ignored.
REQ-039 Random ready_D and memory latency 1-5 cycles -> scoreboard shows in-order sequential PCs, no loss, no duplicates, count never >4.

Source files
------------

// File: rtl/fetch_queue_if.sv
`default_nettype none
// ============================================================================
// fetch_queue_if : redirect, instruction-memory and decode handshake bundle
// Revision       : 1.0
// ============================================================================
interface fetch_queue_if #(
    parameter int N = 64
);
    logic         PCSrc_F;
    logic [N-1:0] PCBranch_F;
    logic         imem_req;
    logic [N-1:0] imem_addr;
    logic         imem_rvalid;
    logic [31:0]  imem_rdata;
    logic         valid_D;
    logic         ready_D;
    logic [31:0]  instr_D;
    logic [N-1:0] pc_D;

    // master: the fetch queue itself; slave: memory, redirect source and decode
    modport master (
        input  PCSrc_F, PCBranch_F, imem_rvalid, imem_rdata, ready_D,
        output imem_req, imem_addr, valid_D, instr_D, pc_D
    );

    modport slave (
        output PCSrc_F, PCBranch_F, imem_rvalid, imem_rdata, ready_D,
        input  imem_req, imem_addr, valid_D, instr_D, pc_D
    );
endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : PC register, single-outstanding imem fetch, DEPTH-entry decode FIFO
// Revision    : 1.0
// ============================================================================
module fetch_queue #(
    parameter int           N        = 64,
    parameter int           DEPTH    = 4,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input wire           clk,
    input wire           reset,
    fetch_queue_if.master bus
);
    localparam int               c_PTR_W   = $clog2(DEPTH);
    localparam int               c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [N-1:0]     c_PC_STEP = N'(4);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         pc_q, pc_d;
    logic [N-1:0]         req_addr_q, req_addr_d;
    logic                 drop_q, drop_d;
    logic [c_CNT_W-1:0]   count_q, count_d;
    logic [c_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

    logic [31:0]          instr_mem [DEPTH];
    logic [N-1:0]         pc_mem    [DEPTH];

    logic                 w_resp;
    logic                 w_keep;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_slot;
    logic                 w_issue;
    logic [c_CNT_W-1:0]   w_occ;
    logic [N-1:0]         w_fetch_pc;

    always_comb begin
        w_resp     = (state_q == S_WAIT) && bus.imem_rvalid;
        w_keep     = w_resp && !drop_q;
        w_push     = w_keep && !bus.PCSrc_F;
        w_pop      = (count_q != '0) && bus.ready_D;
        // Occupancy ignores a same-cycle pop so imem_req never depends on ready_D
        w_occ      = count_q + c_CNT_W'(w_keep);
        w_slot     = (state_q == S_IDLE) || w_resp;
        w_fetch_pc = w_keep ? (pc_q + c_PC_STEP) : pc_q;
        w_issue    = reset && w_slot && !bus.PCSrc_F && (w_occ < c_DEPTH);
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (w_resp) begin
            state_d = S_IDLE;
            drop_d  = 1'b0;
        end
        if (w_push) begin
            pc_d     = pc_q + c_PC_STEP;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (w_issue) begin
            state_d    = S_WAIT;
            req_addr_d = w_fetch_pc;
        end

        // Redirect wins over push/pop; a request still in flight must be discarded
        if (bus.PCSrc_F) begin
            pc_d     = bus.PCBranch_F;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            drop_d   = (state_q == S_WAIT) && !bus.imem_rvalid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            instr_mem[wr_ptr_q] <= bus.imem_rdata;
            pc_mem[wr_ptr_q]    <= req_addr_q;
        end
    end

    assign bus.imem_req  = w_issue;
    assign bus.imem_addr = w_issue ? w_fetch_pc : req_addr_q;
    assign bus.valid_D   = (count_q != '0);
    // Head is forced to zero when empty so reset and flush present clean outputs
    assign bus.instr_D   = bus.valid_D ? instr_mem[rd_ptr_q] : 32'h0;
    assign bus.pc_D      = bus.valid_D ? pc_mem[rd_ptr_q]    : '0;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// tb_fetch_queue : scoreboard bench for fetch_queue (memory model + decode sink)
// Revision       : 1.0
// ============================================================================
module tb_fetch_queue;
    localparam int           N        = 64;
    localparam int           DEPTH    = 4;
    localparam logic [N-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [N-1:0] pc;
        logic [31:0]  data;
    } entry_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_queue_if #(.N(N)) bus ();

    fetch_queue #(.N(N), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    entry_t       exp_q[$];
    logic [N-1:0] popped_q[$];
    logic [N-1:0] exp_fetch_pc;
    logic         outst;
    logic         stale;
    logic [N-1:0] out_addr;

    logic         samp_req    = 1'b0;
    logic [N-1:0] samp_addr   = '0;
    logic         samp_rvalid = 1'b0;

    logic         mem_en     = 1'b1;
    int           lat_min    = 1;
    int           lat_max    = 1;
    logic         mm_rvalid  = 1'b0;
    logic [31:0]  mm_rdata   = '0;
    logic         man_rvalid = 1'b0;
    logic [31:0]  man_rdata  = '0;

    assign bus.imem_rvalid = mem_en ? mm_rvalid : man_rvalid;
    assign bus.imem_rdata  = mem_en ? mm_rdata  : man_rdata;

    function automatic logic [31:0] word_of(input logic [N-1:0] a);
        return a[31:0] ^ 32'hC0DE_1000;
    endfunction

    // Memory: one request at a time, latency drawn from [lat_min, lat_max]
    initial begin
        logic         busy;
        logic [N-1:0] maddr;
        int           cnt;
        busy  = 1'b0;
        maddr = '0;
        cnt   = 0;
        forever begin
            @(posedge clk); #1;
            mm_rvalid = 1'b0;
            if (!mem_en || !reset) begin
                busy = 1'b0;
            end else begin
                if (busy && samp_rvalid) busy = 1'b0;
                if (samp_req) begin
                    busy  = 1'b1;
                    maddr = samp_addr;
                    cnt   = ((lat_max > lat_min) ? $urandom_range(lat_max, lat_min) : lat_min) - 1;
                end else if (busy && cnt > 0) begin
                    cnt = cnt - 1;
                end
                if (busy && cnt == 0) begin
                    mm_rvalid = 1'b1;
                    mm_rdata  = word_of(maddr);
                end
            end
        end
    end

    // Scoreboard: samples 1 time unit before each rising edge
    initial begin
        entry_t e;
        exp_fetch_pc = RESET_PC;
        outst        = 1'b0;
        stale        = 1'b0;
        out_addr     = '0;
        forever begin
            @(negedge clk); #4;
            samp_req    = bus.imem_req;
            samp_addr   = bus.imem_addr;
            samp_rvalid = bus.imem_rvalid;
            if (!reset) begin
                exp_q.delete();
                outst        = 1'b0;
                stale        = 1'b0;
                exp_fetch_pc = RESET_PC;
                checks++;
                if (bus.imem_req !== 1'b0 || bus.valid_D !== 1'b0 || bus.instr_D !== 32'h0 || bus.pc_D !== '0) begin
                    errors++;
                    $display("FAIL sb_reset_outputs: req=%b valid=%b instr=%h pc=%h, required all zero",
                             bus.imem_req, bus.valid_D, bus.instr_D, bus.pc_D);
                end
            end else begin
                checks++;
                if (bus.valid_D !== (exp_q.size() != 0)) begin
                    errors++;
                    $display("FAIL sb_valid: valid_D=%b, required %b (model entries %0d)",
                             bus.valid_D, (exp_q.size() != 0), exp_q.size());
                end
                if (bus.valid_D === 1'b1 && bus.ready_D && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (bus.pc_D !== e.pc || bus.instr_D !== e.data) begin
                        errors++;
                        $display("FAIL sb_head: pc=%h instr=%h, required pc=%h instr=%h",
                                 bus.pc_D, bus.instr_D, e.pc, e.data);
                    end
                    popped_q.push_back(bus.pc_D);
                end
                if (outst && !bus.imem_rvalid) begin
                    checks++;
                    if (bus.imem_req !== 1'b0 || bus.imem_addr !== out_addr) begin
                        errors++;
                        $display("FAIL sb_wait_hold: req=%b addr=%h, required req=0 addr=%h",
                                 bus.imem_req, bus.imem_addr, out_addr);
                    end
                end
                if (bus.imem_rvalid && outst) begin
                    outst = 1'b0;
                    if (!stale && !bus.PCSrc_F) begin
                        e.pc   = out_addr;
                        e.data = bus.imem_rdata;
                        exp_q.push_back(e);
                    end
                end
                if (bus.imem_req === 1'b1) begin
                    checks++;
                    if (bus.imem_addr !== exp_fetch_pc) begin
                        errors++;
                        $display("FAIL sb_req_addr: addr=%h, required %h", bus.imem_addr, exp_fetch_pc);
                    end
                    outst        = 1'b1;
                    stale        = 1'b0;
                    out_addr     = bus.imem_addr;
                    exp_fetch_pc = exp_fetch_pc + N'(4);
                end
                if (bus.PCSrc_F) begin
                    exp_q.delete();
                    exp_fetch_pc = bus.PCBranch_F;
                    if (outst) stale = 1'b1;
                end
                checks++;
                if (exp_q.size() > DEPTH) begin
                    errors++;
                    $display("FAIL sb_occupancy: entries=%0d, required <= %0d", exp_q.size(), DEPTH);
                end
            end
        end
    end

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        popped_q.delete();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.ready_D    = 1'b1;
        bus.PCSrc_F    = 1'b0;
        bus.PCBranch_F = '0;
        lat_min = 1;
        lat_max = 1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.valid_D !== 1'b0 || bus.imem_req !== 1'b0 || bus.instr_D !== 32'h0 || bus.pc_D !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b req=%b instr=%h pc=%h, required all zero",
                     bus.valid_D, bus.imem_req, bus.instr_D, bus.pc_D);
        end
        @(posedge clk); #1;
        popped_q.delete();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL first_request: req=%b addr=%h, required req=1 addr=%h",
                     bus.imem_req, bus.imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        int guard = 0;
        while (popped_q.size() < 4 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (popped_q.size() < 4) begin
            errors++;
            $display("FAIL stream_timeout: pops=%0d, required 4", popped_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (popped_q[i] !== RESET_PC + N'(4 * i)) begin
                    errors++;
                    $display("FAIL stream_order[%0d]: pc=%h, required %h", i, popped_q[i], RESET_PC + N'(4 * i));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        bus.ready_D = 1'b0;
        pulse_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i >= 6) begin
                checks++;
                if (bus.imem_req !== 1'b0 || bus.valid_D !== 1'b1 || bus.pc_D !== RESET_PC ||
                    bus.instr_D !== word_of(RESET_PC)) begin
                    errors++;
                    $display("FAIL stall_head[%0d]: req=%b valid=%b pc=%h instr=%h, required 0 1 %h %h",
                             i, bus.imem_req, bus.valid_D, bus.pc_D, bus.instr_D, RESET_PC, word_of(RESET_PC));
                end
            end
        end
        checks++;
        if (exp_q.size() != DEPTH || exp_fetch_pc !== RESET_PC + N'(16)) begin
            errors++;
            $display("FAIL stall_fill: buffered=%0d next_fetch=%h, required %0d and %h",
                     exp_q.size(), exp_fetch_pc, DEPTH, RESET_PC + N'(16));
        end
        @(posedge clk); #1;
        bus.ready_D = 1'b1;
        do begin
            @(negedge clk);
            guard++;
        end while (bus.imem_req !== 1'b1 && guard < 10);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC + N'(16)) begin
            errors++;
            $display("FAIL resume_addr: req=%b addr=%h, required req=1 addr=%h",
                     bus.imem_req, bus.imem_addr, RESET_PC + N'(16));
        end
        repeat (4) @(negedge clk);
        checks++;
        if (popped_q.size() < 4 || popped_q[0] !== RESET_PC || popped_q[3] !== RESET_PC + N'(12)) begin
            errors++;
            $display("FAIL drain_order: pops=%0d, required first four to be 0,4,8,12 from %h",
                     popped_q.size(), RESET_PC);
        end
    endtask

    task automatic test_redirect_wait();
        int   guard = 0;
        logic seen  = 1'b0;
        lat_min = 3;
        lat_max = 3;
        bus.ready_D = 1'b1;
        pulse_reset();
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.imem_req === 1'b1 && bus.imem_addr === RESET_PC + N'(8)) && guard < 40);
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL redir_wait_setup: no request for %h seen", RESET_PC + N'(8));
        end
        @(posedge clk); #1;
        bus.PCSrc_F    = 1'b1;
        bus.PCBranch_F = N'(32'h100);
        @(posedge clk); #1;
        bus.PCSrc_F    = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_D !== 1'b0) begin
            errors++;
            $display("FAIL redir_flush: valid_D=%b, required 0", bus.valid_D);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (bus.valid_D === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || bus.pc_D !== N'(32'h100) || bus.instr_D !== word_of(N'(32'h100))) begin
            errors++;
            $display("FAIL redir_first_valid: seen=%b pc=%h instr=%h, required pc=100 instr=%h",
                     seen, bus.pc_D, bus.instr_D, word_of(N'(32'h100)));
        end
    endtask

    task automatic test_redirect_rvalid();
        int guard = 0;
        lat_min = 1;
        lat_max = 1;
        bus.ready_D = 1'b0;
        pulse_reset();
        do begin
            @(negedge clk);
            guard++;
        end while (!(bus.imem_rvalid === 1'b1 && exp_q.size() == 3) && guard < 40);
        checks++;
        if (guard >= 40) begin
            errors++;
            $display("FAIL redir_rv_setup: response with 3 buffered not seen");
        end
        #1;
        bus.PCSrc_F    = 1'b1;
        bus.PCBranch_F = N'(32'h200);
        bus.ready_D    = 1'b1;
        @(posedge clk); #1;
        bus.PCSrc_F = 1'b0;
        bus.ready_D = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_D !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== N'(32'h200)) begin
            errors++;
            $display("FAIL redir_rv_next: valid=%b req=%b addr=%h, required 0 1 200",
                     bus.valid_D, bus.imem_req, bus.imem_addr);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.valid_D !== 1'b1 || bus.pc_D !== N'(32'h200)) begin
            errors++;
            $display("FAIL redir_rv_accept: valid=%b pc=%h, required 1 200", bus.valid_D, bus.pc_D);
        end
        bus.ready_D = 1'b1;
    endtask

    task automatic test_random();
        lat_min = 1;
        lat_max = 5;
        bus.ready_D = 1'b1;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            bus.ready_D = ($urandom_range(1, 0) == 1);
        end
        bus.ready_D = 1'b1;
        repeat (40) @(posedge clk);
        checks++;
        if (popped_q.size() < 30 || popped_q[0] !== RESET_PC) begin
            errors++;
            $display("FAIL rand_volume: pops=%0d, required >= 30 starting at %h", popped_q.size(), RESET_PC);
        end
        for (int i = 1; i < popped_q.size(); i++) begin
            checks++;
            if (popped_q[i] !== popped_q[i-1] + N'(4)) begin
                errors++;
                $display("FAIL rand_seq[%0d]: pc=%h, required %h", i, popped_q[i], popped_q[i-1] + N'(4));
            end
        end
    endtask

    task automatic test_reset_wait();
        int guard = 0;
        bus.ready_D = 1'b1;
        man_rvalid  = 1'b0;
        mem_en      = 1'b0;
        pulse_reset();
        do begin
            @(negedge clk);
            guard++;
        end while (bus.imem_req !== 1'b1 && guard < 10);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.imem_req !== 1'b0 || bus.valid_D !== 1'b0 || bus.instr_D !== 32'h0 || bus.pc_D !== '0) begin
            errors++;
            $display("FAIL rw_async: req=%b valid=%b instr=%h pc=%h, required all zero",
                     bus.imem_req, bus.valid_D, bus.instr_D, bus.pc_D);
        end
        @(posedge clk); #1;
        reset      = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== RESET_PC) begin
            errors++;
            $display("FAIL rw_first_req: req=%b addr=%h, required 1 %h", bus.imem_req, bus.imem_addr, RESET_PC);
        end
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_D !== 1'b0) begin
            errors++;
            $display("FAIL rw_stale: valid_D=%b, required 0", bus.valid_D);
        end
        @(posedge clk); #1;
        man_rvalid = 1'b1;
        man_rdata  = word_of(RESET_PC);
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.valid_D !== 1'b1 || bus.pc_D !== RESET_PC || bus.instr_D !== word_of(RESET_PC)) begin
            errors++;
            $display("FAIL rw_real: valid=%b pc=%h instr=%h, required 1 %h %h",
                     bus.valid_D, bus.pc_D, bus.instr_D, RESET_PC, word_of(RESET_PC));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_random();
        test_reset_wait();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
